// File: rtl/food_unit.sv
// Food placement and eat detection for the snake game: a free-running Galois
// LFSR proposes grid cells, the first in-grid cell off the head becomes the food.
module food_unit #(
  parameter int          GRID_W = 40,
  parameter int          GRID_H = 30,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] head_x,
  input  logic [6:0] head_y,
  input  logic       inc_length_check,
  input  logic       isDead,
  input  logic       food_en,
  input  logic [3:0] cnt_status,
  output logic       length_inc,
  output logic [7:0] food_x,
  output logic [6:0] food_y,
  output logic       food_valid,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [9:0] score
);

  typedef enum logic {SEEK = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  food_x_q, food_x_d;
  logic [6:0]  food_y_q, food_y_d;
  logic        length_inc_q, length_inc_d;
  logic [9:0]  score_q, score_d;

  logic [5:0]  cx;
  logic [4:0]  cy;
  logic [7:0]  cand_x;
  logic [6:0]  cand_y;
  logic        cand_valid;
  logic        eat_hit;

  assign cx     = lfsr_q[5:0];
  assign cy     = lfsr_q[12:8];
  assign cand_x = {cx, 2'b00};
  assign cand_y = {cy, 2'b00};

  // Food may land on body segments; only the head cell is excluded.
  assign cand_valid = (int'(cx) < GRID_W) && (int'(cy) < GRID_H) &&
                      !((cand_x == head_x) && (cand_y == head_y));

  assign eat_hit = inc_length_check && (head_x == food_x_q) && (head_y == food_y_q);

  always_comb begin
    state_d      = state_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    score_d      = score_q;
    length_inc_d = 1'b0;
    lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    if (isDead) begin
      score_d = '0;
      state_d = SEEK;
    end else begin
      case (state_q)
        SEEK: begin
          if (cand_valid) begin
            food_x_d = cand_x;
            food_y_d = cand_y;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (eat_hit) begin
            length_inc_d = 1'b1;
            score_d      = (score_q == 10'd1023) ? score_q : score_q + 10'd1;
            state_d      = SEEK;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SEEK;
      lfsr_q       <= SEED;
      food_x_q     <= '0;
      food_y_q     <= '0;
      length_inc_q <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      length_inc_q <= length_inc_d;
      score_q      <= score_d;
    end
  end

  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = (state_q == HOLD);
  assign length_inc = length_inc_q;
  assign score      = score_q;

  // Zero-latency plot path so pixels line up with the FSM's colour output.
  assign plot   = food_en & food_valid;
  assign plot_x = food_x_q + {6'b0, cnt_status[1:0]};
  assign plot_y = food_y_q + {5'b0, cnt_status[3:2]};

endmodule

// File: tb/tb_food_unit.sv
// Directed bench for food_unit: placement, miss, plot sweep, eat, death
// priority, score saturation and asynchronous reset mid-pulse.
module tb_food_unit;

  logic       clk;
  logic       rst;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic       inc_length_check;
  logic       isDead;
  logic       food_en;
  logic [3:0] cnt_status;
  logic       length_inc;
  logic [7:0] food_x;
  logic [6:0] food_y;
  logic       food_valid;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [9:0] score;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_score;

  food_unit dut (
    .clk(clk), .rst(rst), .head_x(head_x), .head_y(head_y),
    .inc_length_check(inc_length_check), .isDead(isDead), .food_en(food_en),
    .cnt_status(cnt_status), .length_inc(length_inc), .food_x(food_x),
    .food_y(food_y), .food_valid(food_valid), .plot(plot), .plot_x(plot_x),
    .plot_y(plot_y), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for placement; an expired bound shows up as a failed check.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (food_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, food_valid}, 32'd1);
  endtask

  // Steer the head onto the food and strobe the eat check for one cycle;
  // returns sampled in the pulse cycle.
  task automatic do_eat(output logic li, output logic [9:0] sc, output logic fv);
    head_x = food_x;
    head_y = food_y;
    inc_length_check = 1'b1;
    @(negedge clk);
    inc_length_check = 1'b0;
    li = length_inc;
    sc = score;
    fv = food_valid;
  endtask

  logic       li;
  logic [9:0] sc;
  logic       fv;
  logic [7:0] old_x;
  logic [6:0] old_y;

  initial begin
    rst = 1'b0; head_x = 8'd0; head_y = 7'd0; inc_length_check = 1'b0;
    isDead = 1'b0; food_en = 1'b0; cnt_status = 4'b0110;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_food_valid", {31'b0, food_valid}, 32'd0);
    check("rst_length_inc", {31'b0, length_inc}, 32'd0);
    check("rst_food_x", {24'b0, food_x}, 32'd0);
    check("rst_food_y", {25'b0, food_y}, 32'd0);
    check("rst_score", {22'b0, score}, 32'd0);
    check("rst_plot", {31'b0, plot}, 32'd0);
    check("rst_plot_x", {24'b0, plot_x}, 32'd2);
    check("rst_plot_y", {25'b0, plot_y}, 32'd1);

    // Initial placement from SEED: cell (33,12)
    rst = 1'b1;
    @(negedge clk);
    check("init_food_x", {24'b0, food_x}, 32'd132);
    check("init_food_y", {25'b0, food_y}, 32'd48);
    check("init_food_valid", {31'b0, food_valid}, 32'd1);
    check("init_length_inc", {31'b0, length_inc}, 32'd0);

    // Miss: adjacent cell
    head_x = 8'd128; head_y = 7'd48; inc_length_check = 1'b1;
    @(negedge clk);
    inc_length_check = 1'b0;
    check("miss_length_inc", {31'b0, length_inc}, 32'd0);
    check("miss_food_x", {24'b0, food_x}, 32'd132);
    check("miss_food_y", {25'b0, food_y}, 32'd48);
    check("miss_score", {22'b0, score}, 32'd0);
    check("miss_food_valid", {31'b0, food_valid}, 32'd1);
    @(negedge clk);
    check("miss_length_inc2", {31'b0, length_inc}, 32'd0);

    // Plot sweep over the 4x4 cell in raster order
    food_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cnt_status = 4'(i);
      #1;
      check("sweep_plot", {31'b0, plot}, 32'd1);
      check("sweep_plot_x", {24'b0, plot_x}, 32'(132 + (i % 4)));
      check("sweep_plot_y", {25'b0, plot_y}, 32'(48 + (i / 4)));
      @(negedge clk);
    end
    food_en = 1'b0;
    #1;
    check("sweep_plot_off", {31'b0, plot}, 32'd0);
    @(negedge clk);

    // Eat the initial food
    do_eat(li, sc, fv);
    check("eat_length_inc", {31'b0, li}, 32'd1);
    check("eat_score", {22'b0, sc}, 32'd1);
    check("eat_food_valid", {31'b0, fv}, 32'd0);
    @(negedge clk);
    check("eat_length_inc_drop", {31'b0, length_inc}, 32'd0);
    check("eat_score_hold", {22'b0, score}, 32'd1);
    wait_valid("eat_replace");
    check("eat_new_not_head", {31'b0, (food_x == head_x) && (food_y == head_y)}, 32'd0);
    check("eat_new_x_grid", {31'b0, (food_x < 8'd160) && (food_x[1:0] == 2'b00)}, 32'd1);
    check("eat_new_y_grid", {31'b0, (food_y < 7'd120) && (food_y[1:0] == 2'b00)}, 32'd1);

    // Death together with a matching eat
    @(negedge clk);
    head_x = food_x; head_y = food_y;
    inc_length_check = 1'b1; isDead = 1'b1;
    #1;
    check("dead_valid_same_cycle", {31'b0, food_valid}, 32'd1);
    @(negedge clk);
    inc_length_check = 1'b0; isDead = 1'b0;
    check("dead_length_inc", {31'b0, length_inc}, 32'd0);
    check("dead_score", {22'b0, score}, 32'd0);
    check("dead_food_valid", {31'b0, food_valid}, 32'd0);

    // Climb to saturation through real eats
    exp_score = 10'd0;
    for (int k = 0; k < 1023; k++) begin
      wait_valid("sat_place");
      exp_score = exp_score + 10'd1;
      exp_q.push_back(exp_score);
      do_eat(li, sc, fv);
      check("sat_length_inc", {31'b0, li}, 32'd1);
      check("sat_score", {22'b0, sc}, {22'b0, exp_q.pop_front()});
    end
    wait_valid("sat_place_final");
    old_x = food_x; old_y = food_y;
    do_eat(li, sc, fv);
    check("sat_hold_length_inc", {31'b0, li}, 32'd1);
    check("sat_hold_score", {22'b0, sc}, 32'd1023);
    check("sat_old_food", {31'b0, (old_x == head_x) && (old_y == head_y)}, 32'd1);

    // Reset asserted in the middle of a pulse
    wait_valid("rstmid_place");
    do_eat(li, sc, fv);
    check("rstmid_pulse", {31'b0, li}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_length_inc", {31'b0, length_inc}, 32'd0);
    check("rstmid_score", {22'b0, score}, 32'd0);
    check("rstmid_food_valid", {31'b0, food_valid}, 32'd0);
    check("rstmid_food_x", {24'b0, food_x}, 32'd0);
    check("rstmid_food_y", {25'b0, food_y}, 32'd0);
    check("rstmid_plot", {31'b0, plot}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
